// File: rtl/fmq_cmd_pkg.sv
// Shared definitions for the levitator board 3-byte UART command frame.
// Used by both the host-side encoder and the board-side decoder.
package fmq_cmd_pkg;

  localparam logic [1:0] OP_SET_OFFSET = 2'b00;
  localparam logic [1:0] OP_RELOAD     = 2'b01;
  localparam logic [1:0] OP_QUERY      = 2'b10;
  localparam logic [1:0] OP_DAC        = 2'b11;

  localparam int CMD_BYTES    = 3;
  localparam int OFFSET_WIDTH = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND0 = 3'd1,
    ST_SEND1 = 3'd2,
    ST_SEND2 = 3'd3,
    ST_ECHO  = 3'd4,
    ST_RESP  = 3'd5,
    ST_FIN   = 3'd6
  } fmq_state_e;

  typedef logic [CMD_BYTES-1:0][7:0] fmq_cmd_bytes_t;

endpackage

// File: rtl/fmq_cmd_pack.sv
// Combinational packing of {op, chan, val} into the 3-byte command frame.
// Only B0 carries bit 7 set, so the decoder can resynchronise on it.
module fmq_cmd_pack
  import fmq_cmd_pkg::*;
(
  input  logic [1:0]     op,
  input  logic [6:0]     chan,
  input  logic [11:0]    val,
  output fmq_cmd_bytes_t bytes
);

  assign bytes[0] = {1'b1, op, chan[6:2]};
  assign bytes[1] = {1'b0, chan[1:0], val[11:7]};
  assign bytes[2] = {1'b0, val[6:0]};

endmodule

// File: rtl/fmq_cmd_encoder.sv
// Host-side command encoder: sends a 3-byte frame, collects the echoes and
// the optional query response. FMQ_ECHO_CHECK_EN adds echo comparison (err_echo).
module fmq_cmd_encoder
  import fmq_cmd_pkg::*;
#(
  parameter int TIMEOUT  = 2500000,
  parameter int TO_WIDTH = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_chan,
  input  logic [11:0] req_val,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic        done,
  output logic        err_timeout,
  output logic [7:0]  resp_data,
  output logic        busy
`ifdef FMQ_ECHO_CHECK_EN
  ,
  output logic        err_echo
`endif
);

  fmq_cmd_bytes_t      pack_bytes;
  fmq_cmd_bytes_t      cmd_bytes;
  logic [1:0]          op_q;
  fmq_state_e          state, state_nxt;
  logic [1:0]          echo_cnt;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                accept, echo_take, waiting, to_hit, to_fire, resp_take, echo_bad;

  fmq_cmd_pack u_pack (
    .op   (req_op),
    .chan (req_chan),
    .val  (req_val),
    .bytes(pack_bytes)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;
  assign m_tvalid  = (state == ST_SEND0) || (state == ST_SEND1) || (state == ST_SEND2);
  assign done      = (state == ST_FIN);
  assign waiting   = (state == ST_ECHO) || (state == ST_RESP);

  // Echoes can overtake the next outgoing byte, so they are counted from SEND0 on.
  assign echo_take = s_tvalid && (echo_cnt != 2'd3) &&
                     (m_tvalid || (state == ST_ECHO));
  assign to_hit    = waiting && !s_tvalid && (to_cnt == TO_WIDTH'(TIMEOUT - 1));

  always_comb begin
    m_tdata = 8'h00;
    case (state)
      ST_SEND0: m_tdata = cmd_bytes[0];
      ST_SEND1: m_tdata = cmd_bytes[1];
      ST_SEND2: m_tdata = cmd_bytes[2];
      default:  m_tdata = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    resp_take = 1'b0;
    to_fire   = 1'b0;
    case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_SEND0;
      ST_SEND0: if (m_tready) state_nxt = ST_SEND1;
      ST_SEND1: if (m_tready) state_nxt = ST_SEND2;
      ST_SEND2: if (m_tready) state_nxt = ST_ECHO;
      ST_ECHO: begin
        if (echo_cnt == 2'd3) begin
          if (op_q == OP_QUERY && !echo_bad) begin
            // response may directly follow the third echo
            if (s_tvalid) begin
              resp_take = 1'b1;
              state_nxt = ST_FIN;
            end else begin
              state_nxt = ST_RESP;
            end
          end else begin
            state_nxt = ST_FIN;
          end
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      ST_RESP: begin
        if (s_tvalid) begin
          resp_take = 1'b1;
          state_nxt = ST_FIN;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      s_tready    <= 1'b0;
      cmd_bytes   <= '0;
      op_q        <= 2'b00;
      echo_cnt    <= 2'd0;
      err_timeout <= 1'b0;
      resp_data   <= 8'h00;
      to_cnt      <= '0;
    end else begin
      state    <= state_nxt;
      s_tready <= 1'b1;
      if (accept) begin
        cmd_bytes   <= pack_bytes;
        op_q        <= req_op;
        echo_cnt    <= 2'd0;
        err_timeout <= 1'b0;
      end else begin
        if (echo_take) echo_cnt <= echo_cnt + 2'd1;
        if (to_fire)   err_timeout <= 1'b1;
      end
      if (resp_take) resp_data <= s_tdata;
      if (!waiting || s_tvalid) to_cnt <= '0;
      else                      to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef FMQ_ECHO_CHECK_EN
  logic [7:0] echo_exp;

  always_comb begin
    echo_exp = cmd_bytes[0];
    case (echo_cnt)
      2'd1:    echo_exp = cmd_bytes[1];
      2'd2:    echo_exp = cmd_bytes[2];
      default: echo_exp = cmd_bytes[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   err_echo <= 1'b0;
    else if (accept)                            err_echo <= 1'b0;
    else if (echo_take && s_tdata != echo_exp)  err_echo <= 1'b1;
  end

  assign echo_bad = err_echo;
`else
  assign echo_bad = 1'b0;
`endif

endmodule

// File: tb/tb_fmq_cmd_encoder.sv
// Directed bench for fmq_cmd_encoder: a UART loopback responder plus
// table-driven commands and hand sequences for timeout, reset and echo corruption.
module tb_fmq_cmd_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = '0;
  logic [6:0]  req_chan = '0;
  logic [11:0] req_val = '0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tready;
  logic        done, err_timeout, busy;
  logic [7:0]  resp_data;
`ifdef FMQ_ECHO_CHECK_EN
  logic        err_echo;
`endif

  fmq_cmd_encoder #(.TIMEOUT(100), .TO_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_chan(req_chan), .req_val(req_val),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .done(done), .err_timeout(err_timeout), .resp_data(resp_data), .busy(busy)
`ifdef FMQ_ECHO_CHECK_EN
    , .err_echo(err_echo)
`endif
  );

  always #5 clk = ~clk;

  int ntests = 0, nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // responder / monitor state
  int         echo_limit = 3, corrupt_idx = -1, stall_n = 0, resp_gap = 0;
  logic [7:0] corrupt_val = 8'h00, resp_byte = 8'h00;
  bit         resp_en = 1'b0;
  logic [7:0] sent_q[$];
  int         rx_q[$];
  int         rx_cyc[8];
  int         nsent = 0, rx_cnt = 0, stall_cnt = 0, done_cnt = 0, done_cyc = 0;
  bit         hs_prev = 1'b0;
  logic [7:0] hs_byte = 8'h00, stall_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clr();
    sent_q.delete();
    rx_q.delete();
    nsent = 0; rx_cnt = 0; stall_cnt = 0; done_cnt = 0; done_cyc = 0; hs_prev = 1'b0;
    foreach (rx_cyc[i]) rx_cyc[i] = 0;
  endtask

  // UART loopback: echoes each accepted byte, optionally stalls and appends a response
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        hs_prev = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
      end else begin
        if (hs_prev) begin
          sent_q.push_back(hs_byte);
          if (nsent < echo_limit)
            rx_q.push_back((nsent == corrupt_idx) ? int'(corrupt_val) : int'(hs_byte));
          nsent++;
          if (nsent == 3 && resp_en) begin
            repeat (resp_gap) rx_q.push_back(-1);
            rx_q.push_back(int'(resp_byte));
          end
        end
        s_tvalid = 1'b0;
        if (rx_q.size() > 0) begin
          int b;
          b = rx_q.pop_front();
          if (b >= 0) begin
            s_tvalid = 1'b1;
            s_tdata  = b[7:0];
            if (rx_cnt < 8) rx_cyc[rx_cnt] = cyc;
            rx_cnt++;
          end
        end
        if (m_tvalid) begin
          if (stall_cnt < stall_n) begin
            if (stall_cnt == 0) stall_byte = m_tdata;
            else check("stall_hold", m_tdata, stall_byte);
            m_tready = 1'b0;
            stall_cnt++;
          end else begin
            m_tready = 1'b1;
          end
        end else begin
          m_tready = 1'b0;
        end
        hs_prev = m_tvalid && m_tready;
        hs_byte = m_tdata;
        if (hs_prev) stall_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [6:0] chan, input logic [11:0] val,
                         output bit ok);
    model_clr();
    req_op = op; req_chan = chan; req_val = val; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) step();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  chan;
    logic [11:0] val;
    int          stall;
    bit          resp;
    logic [7:0]  rbyte;
    int          gap;
    logic [7:0]  e0, e1, e2;
  } vec_t;

  vec_t       vt[6];
  logic [7:0] exp_resp;
  bit         ok;

  initial begin
    vt[0] = '{2'b00, 7'd37,  12'h9A5, 0, 1'b0, 8'h00, 0, 8'h89, 8'h33, 8'h25};
    vt[1] = '{2'b10, 7'd0,   12'h000, 0, 1'b1, 8'h58, 0, 8'hC0, 8'h00, 8'h00};
    vt[2] = '{2'b11, 7'h45,  12'h0AB, 0, 1'b0, 8'h00, 0, 8'hF1, 8'h21, 8'h2B};
    vt[3] = '{2'b01, 7'h7F,  12'hFFF, 5, 1'b0, 8'h00, 0, 8'hBF, 8'h7F, 8'h7F};
    vt[4] = '{2'b00, 7'h02,  12'h800, 0, 1'b0, 8'h00, 0, 8'h80, 8'h50, 8'h00};
    vt[5] = '{2'b10, 7'h11,  12'h123, 2, 1'b1, 8'hA7, 3, 8'hC4, 8'h22, 8'h23};
    exp_resp = 8'h00;

    // reset state
    step(); step();
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_done", done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_resp_data", resp_data, 0);
    rst = 1'b1;
    step();
    check("post_rst_s_tready", s_tready, 1);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);

    // stray bytes in IDLE are dropped
    model_clr();
    rx_q.push_back(8'h55); rx_q.push_back(8'hC3);
    repeat (4) step();
    check("idle_rx_req_ready", req_ready, 1);
    check("idle_rx_done", done_cnt, 0);
    check("idle_rx_resp", resp_data, exp_resp);

    foreach (vt[i]) begin
      stall_n = vt[i].stall; resp_en = vt[i].resp; resp_byte = vt[i].rbyte;
      resp_gap = vt[i].gap; echo_limit = 3; corrupt_idx = -1;
      run_cmd(vt[i].op, vt[i].chan, vt[i].val, ok);
      if (vt[i].resp) exp_resp = vt[i].rbyte;
      check($sformatf("v%0d_done_seen", i), ok, 1);
      check($sformatf("v%0d_nbytes", i), sent_q.size(), 3);
      if (sent_q.size() == 3) begin
        check($sformatf("v%0d_b0", i), sent_q[0], vt[i].e0);
        check($sformatf("v%0d_b1", i), sent_q[1], vt[i].e1);
        check($sformatf("v%0d_b2", i), sent_q[2], vt[i].e2);
      end
      check($sformatf("v%0d_done_once", i), done_cnt, 1);
      check($sformatf("v%0d_err_timeout", i), err_timeout, 0);
      check($sformatf("v%0d_resp", i), resp_data, exp_resp);
      check($sformatf("v%0d_req_ready", i), req_ready, 1);
`ifdef FMQ_ECHO_CHECK_EN
      check($sformatf("v%0d_err_echo", i), err_echo, 0);
`endif
    end

    // timeout: only two echoes come back
    stall_n = 0; resp_en = 1'b0; echo_limit = 2;
    run_cmd(2'b00, 7'd1, 12'h000, ok);
    check("to_done_seen", ok, 1);
    check("to_err_timeout", err_timeout, 1);
    check("to_done_once", done_cnt, 1);
    check("to_latency", done_cyc - (rx_cyc[1] + 1), 100);
    check("to_resp_held", resp_data, exp_resp);
    echo_limit = 3;

    // corrupted second echo on a query
    resp_en = 1'b1; resp_byte = 8'h99; resp_gap = 0;
    corrupt_idx = 1; corrupt_val = 8'h54;
    run_cmd(2'b10, 7'd0, 12'h000, ok);
    check("ec_done_seen", ok, 1);
    check("ec_err_timeout_cleared", err_timeout, 0);
    check("ec_done_once", done_cnt, 1);
`ifdef FMQ_ECHO_CHECK_EN
    check("ec_err_echo", err_echo, 1);
    check("ec_done_after_echo3", done_cyc - (rx_cyc[2] + 1), 1);
`else
    exp_resp = 8'h99;
`endif
    check("ec_resp", resp_data, exp_resp);
    corrupt_idx = -1; resp_en = 1'b0;

    // reset while the second byte is stalled
    stall_n = 20;
    model_clr();
    req_op = 2'b10; req_chan = 7'd5; req_val = 12'h000; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 100 && nsent < 1; i++) step();
    check("mr_reached_send1", nsent, 1);
    repeat (3) step();
    check("mr_stalled_valid", m_tvalid, 1);
    rst = 1'b0;
    #1;
    check("mr_in_rst_m_tvalid", m_tvalid, 0);
    check("mr_in_rst_s_tready", s_tready, 0);
    step();
    rst = 1'b1;
    stall_n = 0;
    step();
    check("mr_req_ready", req_ready, 1);
    check("mr_m_tvalid", m_tvalid, 0);
    run_cmd(2'b01, 7'd0, 12'h000, ok);
    check("mr_done_seen", ok, 1);
    check("mr_nbytes", sent_q.size(), 3);
    if (sent_q.size() == 3) begin
      check("mr_b0", sent_q[0], 8'hA0);
      check("mr_b1", sent_q[1], 8'h00);
      check("mr_b2", sent_q[2], 8'h00);
    end
`ifdef FMQ_ECHO_CHECK_EN
    check("mr_err_echo_cleared", err_echo, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
